// File: rtl/sample_out_buf.sv
// Show-ahead circular FIFO between the FIR output and the sample consumer, with drop-newest overflow.
// Optional dropped-sample counter is built when SAMPLE_OUT_BUF_OVF_CNT_EN is defined.
module sample_out_buf #(
   parameter int WIDTH     = 12,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_strobe,
   input  logic                     in_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     afull,
   output logic                     overflow,
   input  logic                     ovf_clr,
   output logic [15:0]              ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             afull_q, afull_d;
   logic             ovf_q, ovf_d;

   logic push_req, pop, full, push, drop;

   assign push_req = in_strobe & in_valid;
   assign pop      = (level_q != '0) & out_ready;
   assign full     = (level_q == LW'(DEPTH));
   // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      afull_d = (level_d >= LW'(AFULL_LVL));
      ovf_d   = ovf_clr ? 1'b0 : (ovf_q | drop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= in_data;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef SAMPLE_OUT_BUF_OVF_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Clear wins over a same-cycle drop; the count saturates instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (ovf_clr)                        cnt_d = '0;
      else if (drop && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign ovf_cnt = cnt_q;
`else
   assign ovf_cnt = '0;
`endif

   assign out_data  = mem_q[rd_ptr_q];
   assign out_valid = (level_q != '0);
   assign level     = level_q;
   assign afull     = afull_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_sample_out_buf.sv
// Directed bench for sample_out_buf: fill/drain order, overflow, full push+pop, wrap, reset.
module tb_sample_out_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] in_data;
   logic        in_strobe, in_valid;
   logic [11:0] out_data;
   logic        out_valid, out_ready;
   logic [4:0]  level;
   logic        afull, overflow, ovf_clr;
   logic [15:0] ovf_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int maxlev;

   sample_out_buf #(.WIDTH(12), .DEPTH(16), .AFULL_LVL(12)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .afull(afull), .overflow(overflow), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] d);
      in_data   = d;
      in_strobe = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_strobe = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_strobe = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; ovf_clr = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_level", level, 0);
      check("rst_afull", afull, 0);
      check("rst_overflow", overflow, 0);
      check("rst_ovf_cnt", ovf_cnt, 0);
      check("rst_out_data", out_data, 0);
      tick(); tick();
      rst = 1'b0;

      // Five pushes, no consumer
      for (int i = 0; i < 5; i++) push(12'h800 + 12'(i));
      check("t1_level", level, 5);
      check("t1_out_valid", out_valid, 1);
      check("t1_out_data", out_data, 12'h800);
      check("t1_afull", afull, 0);

      // Fill to 16, then two dropped strobes
      for (int i = 5; i < 16; i++) begin
         push(12'h800 + 12'(i));
         if (i == 10) check("t2_afull_at11", afull, 0);
         if (i == 11) check("t2_afull_at12", afull, 1);
      end
      check("t2_ovf_before_drop", overflow, 0);
      push(12'h8A0);
      push(12'h8A1);
      check("t2_level", level, 16);
      check("t2_afull", afull, 1);
      check("t2_overflow", overflow, 1);
`ifdef SAMPLE_OUT_BUF_OVF_CNT_EN
      check("t2_ovf_cnt", ovf_cnt, 2);
`else
      check("t2_ovf_cnt", ovf_cnt, 0);
`endif
      check("t2_head_kept", out_data, 12'h800);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("t2_drain_data", out_data, 12'h800 + 12'(i));
         tick();
      end
      out_ready = 1'b0;
      check("t2_empty_level", level, 0);
      check("t2_empty_valid", out_valid, 0);
      check("t2_ovf_sticky", overflow, 1);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("t2_ovf_cleared", overflow, 0);
      check("t2_cnt_cleared", ovf_cnt, 0);

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 16; i++) push(12'h100 + 12'(i));
      check("t3_full_level", level, 16);
      out_ready = 1'b1;
      check("t3_pop_oldest", out_data, 12'h100);
      push(12'h1FF);
      out_ready = 1'b0;
      check("t3_level_kept", level, 16);
      check("t3_no_overflow", overflow, 0);
      check("t3_head_adv", out_data, 12'h101);

      // Clear wins over a same-cycle drop
      ovf_clr = 1'b1;
      push(12'h222);
      ovf_clr = 1'b0;
      check("t3_clr_prio_ovf", overflow, 0);
      check("t3_clr_prio_cnt", ovf_cnt, 0);
      push(12'h333);
      check("t3_drop_ovf", overflow, 1);
`ifdef SAMPLE_OUT_BUF_OVF_CNT_EN
      check("t3_drop_cnt", ovf_cnt, 1);
`else
      check("t3_drop_cnt", ovf_cnt, 0);
`endif
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("t3_clr_ovf", overflow, 0);
      out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         check("t3_drain_data", out_data, 12'h100 + 12'(i));
         tick();
      end
      check("t3_tail_data", out_data, 12'h1FF);
      tick();
      out_ready = 1'b0;
      check("t3_empty", level, 0);

      // Strobes without in_valid are ignored
      in_valid = 1'b0; in_strobe = 1'b1; in_data = 12'h555;
      tick(); tick(); tick();
      in_strobe = 1'b0;
      check("t4_level", level, 0);
      check("t4_valid", out_valid, 0);
      check("t4_overflow", overflow, 0);

      // Streaming across pointer wrap, consumer always ready
      out_ready = 1'b1;
      maxlev = 0;
      for (int k = 0; k < 40; k++) begin
         push(12'h300 + 12'(k));
         check("t5_valid", out_valid, 1);
         check("t5_data", out_data, 12'h300 + 12'(k));
         check("t5_level", level, 1);
         for (int c = 0; c < 11; c++) begin
            tick();
            if (int'(level) > maxlev) maxlev = int'(level);
         end
      end
      check("t5_maxlev", maxlev, 0);
      out_ready = 1'b0;

      // Reset mid-operation with level 7 and overflow set
      for (int i = 0; i < 17; i++) push(12'h600 + 12'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      out_ready = 1'b0;
      check("t6_level7", level, 7);
      check("t6_ovf_set", overflow, 1);
      check("t6_head", out_data, 12'h609);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_level", level, 0);
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_afull", afull, 0);
      check("t6_rst_cnt", ovf_cnt, 0);
      tick();
      rst = 1'b0;
      push(12'hABC);
      check("t6_post_data", out_data, 12'hABC);
      check("t6_post_level", level, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_out_buf.md
# sample_out_buf

Output sample buffer placed directly downstream of the fixed-point FIR filter. It captures each 12-bit offset-binary result when the filter's per-sample strobe fires and its valid flag is high. Samples are held in a circular FIFO and presented to the consumer (DAC serializer or capture interface) over a ready/valid handshake. Overflow is detected and reported, so the consumer's back-pressure never corrupts the filter pipeline.

## Interface
Parameters:
- WIDTH, 12, sample width in bits (matches filter output width)
- DEPTH, 16, FIFO entries; power of two, ≥ 2
- AFULL_LVL, 12, almost-full threshold in entries; 1 ≤ AFULL_LVL ≤ DEPTH

Ports:
- clk  in  1  single clock, same domain as the filter's fast clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  filter result (offset binary); sampled only on a push
- in_strobe  in  1  one-cycle pulse, once per downsampled sample period
- in_valid  in  1  filter pipeline-filled flag; level signal
- out_data  out  WIDTH  head-of-FIFO sample (show-ahead)
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- afull  out  1  level ≥ AFULL_LVL
- overflow  out  1  sticky; a sample was dropped
- ovf_clr  in  1  synchronous clear of overflow (and ovf_cnt)
- ovf_cnt  out  16  dropped-sample count (see Configuration)

## Operation
- Push request: in_strobe && in_valid. Strobes while in_valid = 0 are ignored; they do not count as drops.
- Pop: out_valid && out_ready.
- Push is accepted when level < DEPTH, or when level == DEPTH and a pop occurs in the same cycle.
- Push on full without a pop: the new sample is dropped and existing contents are preserved (drop-newest). overflow sets on the next edge.
- Storage: DEPTH×WIDTH register array, with write pointer wr_ptr and read pointer rd_ptr of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH.
- level is a separate counter:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop
- out_data = mem[rd_ptr], combinational from the array. Valid whenever out_valid = 1.
- out_valid = (level != 0). out_data is don't-care when out_valid = 0 but must not be X after reset (array is reset to 0).
- Pop while empty is impossible by definition, because out_valid gates it.
- ovf_clr has priority over a same-cycle drop: the register clears, and that cycle's drop is not recorded.
- Data is passed through unmodified. No sign or format conversion is done.

## Timing
- Reset values (async, applied immediately):
  - out_valid = 0, level = 0, afull = 0
  - overflow = 0, ovf_cnt = 0
  - out_data = 0, both pointers = 0
- First-word latency: a push at edge N makes out_valid = 1 and shows the sample on out_data after edge N.
- Push and pop on the same cycle at level = 1: out_valid stays 1 and out_data advances to the new sample.
- Throughput: one push and one pop per clk cycle.
- Reset asserted mid-operation: contents are discarded, all outputs return to reset values, and no partial sample is emitted. A push coincident with reset release is captured normally on the next active edge.
- afull and level are registered and updated on the same edge as the pointers.

## Configuration
- Macro SAMPLE_OUT_BUF_OVF_CNT_EN.
- Defined: ovf_cnt increments on each dropped push, saturates at 16'hFFFF, and is cleared by ovf_clr or rst.
- Undefined: no counter logic is built and ovf_cnt is tied to 0. overflow behaviour is identical in both builds.

## Test plan
- Reset then 5 strobes with in_valid = 1, data 0x800..0x804, out_ready = 0 → level = 5, out_valid = 1, out_data = 0x800, afull = 0.
- Continue to 16 pushes, then 2 more strobes → level = 16, afull = 1 since push 12, overflow = 1, ovf_cnt = 2 (macro on) or 0 (macro off); popping all 16 yields the first 16 values in order.
- Full FIFO, push and pop in the same cycle → pop returns the oldest entry, the new sample is accepted at the tail, level stays 16, overflow stays 0.
- Strobes with in_valid = 0 → level stays 0, overflow stays 0.
- out_ready = 1 continuously, one strobe every 12 cycles, 40 samples crossing pointer wrap → each sample visible one cycle after its push, in order, level never exceeds 1.
- Reset asserted with level = 7 and overflow = 1 → all outputs are 0 immediately; the next push gives out_data equal to that sample, level = 1.
